// File: rtl/mem_wb_skid_reg_if.sv
// MEM->WB handshake bundle: upstream entry fields, downstream head fields and occupancy.
// The master side drives the upstream entry and consumes the head; the stage itself is the slave.
interface mem_wb_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DST_W-1:0]  in_dst;
    logic [DATA_W-1:0] in_alu_res;
    logic [DATA_W-1:0] in_mem;
    logic              in_mem_read;
    logic              in_wb_en;

    logic              out_valid;
    logic              out_ready;
    logic [DST_W-1:0]  out_dst;
    logic [DATA_W-1:0] out_alu_res;
    logic [DATA_W-1:0] out_mem;
    logic              out_mem_read;
    logic              out_wb_en;
    logic [DATA_W-1:0] out_wb_data;
    logic              out_wb_fire;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_dst, in_alu_res, in_mem, in_mem_read, in_wb_en, out_ready,
        input  in_ready, out_valid, out_dst, out_alu_res, out_mem, out_mem_read,
        input  out_wb_en, out_wb_data, out_wb_fire, occupancy
    );

    modport slave (
        input  in_valid, in_dst, in_alu_res, in_mem, in_mem_read, in_wb_en, out_ready,
        output in_ready, out_valid, out_dst, out_alu_res, out_mem, out_mem_read,
        output out_wb_en, out_wb_data, out_wb_fire, occupancy
    );
endinterface

// File: rtl/mem_wb_skid_reg.sv
// MEM->WB stage register with a 2-entry skid buffer (head + skid), registered in_ready,
// synchronous flush and the write-back data mux on the head entry.
module mem_wb_skid_reg #(
    parameter int DATA_W = 32,
    parameter int DST_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    mem_wb_skid_reg_if.slave bus
);
    typedef struct packed {
        logic [DST_W-1:0]  dst;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem;
        logic              mem_read;
        logic              wb_en;
    } entry_t;

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t in_entry;
    logic   accept;
    logic   rel;

    assign in_entry = '{dst:      bus.in_dst,
                        alu_res:  bus.in_alu_res,
                        mem:      bus.in_mem,
                        mem_read: bus.in_mem_read,
                        wb_en:    bus.in_wb_en};

    assign bus.in_ready  = (state_q != TWO);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.occupancy = state_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign rel    = bus.out_valid & bus.out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            // Payload is left untouched; it is don't-care once the stage is empty.
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        head_d  = in_entry;
                    end
                end
                ONE: begin
                    if (accept && rel) begin
                        head_d = in_entry;
                    end else if (accept) begin
                        state_d = TWO;
                        skid_d  = in_entry;
                    end else if (rel) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (rel) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.out_dst      = head_q.dst;
    assign bus.out_alu_res  = head_q.alu_res;
    assign bus.out_mem      = head_q.mem;
    assign bus.out_mem_read = head_q.mem_read;
    assign bus.out_wb_en    = head_q.wb_en;
    assign bus.out_wb_data  = head_q.mem_read ? head_q.mem : head_q.alu_res;
    assign bus.out_wb_fire  = bus.out_valid & bus.out_ready & head_q.wb_en;
endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM→WB pipeline stage register: successor to the freeze-only MEM/WB latch. It replaces the global freeze with a per-stage valid/ready handshake and adds a 2-entry skid buffer, so `in_ready` is fully registered. It also adds a synchronous flush and a write-back data mux. It sits between the data-memory stage and the register-file write port; WB and the hazard unit consume its head entry.

## Interface
- `DATA_W`, 32, width of ALU result and memory read data
- `DST_W`, 4, destination register index width (register-file depth bits)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous kill of all held entries
- `in_valid`  in  1  upstream entry present
- `in_ready`  out  1  stage can accept; driven only from state register
- `in_dst`  in  DST_W  destination register
- `in_alu_res`  in  DATA_W  ALU result
- `in_mem`  in  DATA_W  memory read data
- `in_mem_read`  in  1  entry is a load
- `in_wb_en`  in  1  entry writes the register file
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  downstream consumes head this cycle
- `out_dst`, `out_alu_res`, `out_mem`, `out_mem_read`, `out_wb_en`  out  as inputs  head entry fields
- `out_wb_data`  out  DATA_W  `out_mem_read ? out_mem : out_alu_res`
- `out_wb_fire`  out  1  `out_valid & out_ready & out_wb_en`
- `occupancy`  out  2  entries held: 0, 1 or 2

## Operation
- Storage: head register H (drives `out_*`) and skid register S, each holding {dst, alu_res, mem, mem_read, wb_en}.
- accept = `in_valid & in_ready`; release = `out_valid & out_ready`.
- States (encoded by `occupancy`):
  - EMPTY: `out_valid`=0, `in_ready`=1.
  - ONE: `out_valid`=1, `in_ready`=1.
  - TWO: `out_valid`=1, `in_ready`=0.
- Transitions:
  - EMPTY: accept → ONE, H←in.
  - ONE: accept & release → ONE, H←in. Accept & ~release → TWO, S←in. ~accept & release → EMPTY. Otherwise hold.
  - TWO: release → ONE, H←S. Otherwise hold. No accept is possible in TWO.
- Priority: `rst` > `flush` > handshake.
  - `flush`: next state EMPTY. Any accept or release in the same cycle is discarded. The payload registers hold their values but are don't-care.
- `rst`: state EMPTY; H and S payload cleared to 0.
- `out_wb_data` and `out_wb_fire` are combinational from H and `out_ready`. No other comb path exists from inputs to outputs, except `out_wb_fire` from `out_ready`.
- While `out_valid`=1 and `out_ready`=0, H is stable and all `out_*` fields are unchanged.
- Order is strictly FIFO; entries are never dropped except by `flush`/`rst`.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1, `occupancy`=0, every `out_*` payload field and `out_wb_data`=0, `out_wb_fire`=0.
- Latency: accept in cycle N with stage EMPTY → `out_valid`=1 with that entry in N+1.
- Throughput: 1 entry/cycle sustained while `out_ready`=1; occupancy stays ≤1.
- Backpressure: first cycle with `out_ready`=0 and an accept → TWO next cycle, `in_ready`=0 from that cycle. The skid slot absorbs the one entry sent before upstream sees `in_ready` low.
- Recovery: from TWO, one release → ONE and `in_ready`=1 next cycle.
- Flush in cycle N → `out_valid`=0, `in_ready`=1, `occupancy`=0 in N+1. Accept is allowed again in N+1.
- Reset asserted mid-transfer: same as flush, plus payload zeroed. `rst` is sampled only on `clk` rising edge.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → `out_valid`=0, `in_ready`=1, `occupancy`=0, `out_wb_data`=0.
- Streaming: 8 entries, dst=1..8, alu_res=0x100+i, `out_ready`=1 → outputs appear 1 cycle after each accept, in order, `occupancy`≤1.
- Skid:
  - Send A (alu=0xA), B (alu=0xB) back-to-back with `out_ready`=0 → `occupancy`=2, `in_ready`=0, head=A.
  - Raise `out_ready` → A then B on consecutive cycles, `in_ready`=1 the cycle after A leaves.
- WB mux: entry mem_read=1, mem=0xDEAD, alu=0x1234, wb_en=1 with `out_ready`=1 → `out_wb_data`=0xDEAD, `out_wb_fire`=1. Same entry with mem_read=0 → 0x1234.
- Flush in TWO with simultaneous `in_valid`=1 and `out_ready`=1 → next cycle `occupancy`=0, `out_valid`=0; neither the held nor the offered entry is ever output.
- Random valid/ready (10k cycles) against a FIFO scoreboard → no loss, duplication or reorder; `in_ready` never high while `occupancy`=2.
